// File: rtl/demux1_2_line_pkg.sv
// Shared types and default widths for the line-alternating 1:2 pixel demultiplexer.
package demux1_2_line_pkg;

  localparam int unsigned DEF_DATA_LENGTH = 8;
  localparam int unsigned DEF_LINE_WIDTH  = 8;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  typedef enum logic {
    LANE1 = 1'b0,
    LANE2 = 1'b1
  } lane_t;

endpackage

// File: rtl/demux1_2_line_lane_fifo2.sv
// Two-entry first-word-fall-through FIFO; head register drives the lane output directly.
module lane_fifo2
  import demux1_2_line_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         valid
);

  fifo_state_t  state, state_nxt;
  logic [W-1:0] head, tail;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FIFO_EMPTY: if (push) state_nxt = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_nxt = FIFO_FULL;
        else if (!push && pop) state_nxt = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) state_nxt = FIFO_ONE;
      default:    state_nxt = FIFO_EMPTY;
    endcase
    if (clear) state_nxt = FIFO_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIFO_EMPTY;
    else        state <= state_nxt;
  end

  // A full FIFO ignores push even while popping, so in_ready never depends on out*_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        FIFO_EMPTY: if (push) head <= push_data;
        FIFO_ONE: begin
          if (push && pop) head <= push_data;
          else if (push)   tail <= push_data;
        end
        FIFO_FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign full     = (state == FIFO_FULL);
  assign valid    = (state != FIFO_EMPTY);
  assign pop_data = head;

endmodule

// File: rtl/demux1_2_line.sv
// Line-alternating 1:2 pixel demultiplexer: whole lines are steered alternately to
// lane 1 and lane 2, each lane buffered by a 2-entry FIFO.
module demux1_2_line
  import demux1_2_line_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int unsigned LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int unsigned CNT_W       = $clog2(LINE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [DATA_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_LENGTH-1:0] out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [DATA_LENGTH-1:0] out2_data,
  output logic                   out2_valid,
  input  logic                   out2_ready,
  output logic                   line_sel,
  output logic [CNT_W-1:0]       col
);

  lane_t      sel;
  logic       full1, full2;
  logic       accept, push1, push2, pop1, pop2;
  logic [CNT_W-1:0] col_q;

  assign in_ready = (sel == LANE2) ? !full2 : !full1;
  assign accept   = in_valid && in_ready && !clear;
  assign push1    = accept && (sel == LANE1);
  assign push2    = accept && (sel == LANE2);
  assign pop1     = out1_valid && out1_ready;
  assign pop2     = out2_valid && out2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= LANE1;
      col_q <= '0;
    end else if (clear) begin
      sel   <= LANE1;
      col_q <= '0;
    end else if (accept) begin
      if (col_q == CNT_W'(LINE_WIDTH - 1)) begin
        col_q <= '0;
        sel   <= (sel == LANE1) ? LANE2 : LANE1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign line_sel = sel;
  assign col      = col_q;

  lane_fifo2 #(.W(DATA_LENGTH)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (pop1),
    .pop_data  (out1_data),
    .valid     (out1_valid)
  );

  lane_fifo2 #(.W(DATA_LENGTH)) u_lane2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push2),
    .push_data (in_data),
    .full      (full2),
    .pop       (pop2),
    .pop_data  (out2_data),
    .valid     (out2_valid)
  );

endmodule

// File: tb/tb_demux1_2_line.sv
// Directed bench for demux1_2_line (8-bit pixels, 4-pixel lines) plus a randomised scoreboard run.
module tb_demux1_2_line;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1_data, out2_data;
  logic       out1_valid, out2_valid;
  logic       out1_ready, out2_ready;
  logic       line_sel;
  logic [1:0] col;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux1_2_line #(.DATA_LENGTH(8), .LINE_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .line_sel   (line_sel),
    .col        (col)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    chk("send_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out2_valid", out2_valid, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_out2_data", out2_data, 0);
    chk("rst_line_sel", line_sel, 0);
    chk("rst_col", col, 0);
    rst_n = 1'b1;
    tick();

    // Streaming: 12 pixels, both lanes ready
    for (int i = 0; i < 12; i++) begin
      chk("s_col_pre", col, i % 4);
      chk("s_sel_pre", line_sel, (i / 4) % 2);
      send(8'(i + 1));
      if (((i / 4) % 2) == 0) begin
        chk("s_out1_valid", out1_valid, 1);
        chk("s_out1_data", out1_data, i + 1);
        chk("s_out2_idle", out2_valid, 0);
      end else begin
        chk("s_out2_valid", out2_valid, 1);
        chk("s_out2_data", out2_data, i + 1);
        chk("s_out1_idle", out1_valid, 0);
      end
      chk("s_col_post", col, (i + 1) % 4);
      chk("s_sel_post", line_sel, ((i + 1) / 4) % 2);
    end
    tick();
    chk("s_drained1", out1_valid, 0);
    chk("s_drained2", out2_valid, 0);

    // Lane-1 stall
    do_clear();
    chk("clr_sel", line_sel, 0);
    out1_ready = 1'b0;
    send(8'h10);
    chk("st_head10", out1_data, 8'h10);
    chk("st_ready_one", in_ready, 1);
    send(8'h11);
    chk("st_full", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h12;
    tick();
    chk("st_blocked", in_ready, 0);
    chk("st_col_held", col, 2);
    chk("st_head_stable", out1_data, 8'h10);
    out1_ready = 1'b1;
    tick();
    chk("st_pop10", out1_data, 8'h11);
    chk("st_ready_back", in_ready, 1);
    chk("st_col_still", col, 2);
    tick();
    in_valid = 1'b0;
    chk("st_head12", out1_data, 8'h12);
    chk("st_col3", col, 3);
    tick();
    chk("st_empty", out1_valid, 0);

    // Cross-lane independence
    do_clear();
    for (int k = 0; k < 4; k++) send(8'(8'h20 + k));
    send(8'h30);
    send(8'h31);
    send(8'h32);
    out2_ready = 1'b0;
    send(8'h33);
    for (int k = 0; k < 4; k++) begin
      send(8'(8'h40 + k));
      chk("x_out1_valid", out1_valid, 1);
      chk("x_out1_data", out1_data, 8'h40 + k);
      chk("x_out2_hold_v", out2_valid, 1);
      chk("x_out2_hold_d", out2_data, 8'h32);
    end
    chk("x_sel_lane2", line_sel, 1);
    chk("x_rdy_blocked", in_ready, 0);
    out2_ready = 1'b1;
    tick();
    chk("x_out2_second", out2_data, 8'h33);
    chk("x_out2_second_v", out2_valid, 1);
    tick();
    chk("x_out2_empty", out2_valid, 0);

    // Clear colliding with an accept
    do_clear();
    for (int k = 0; k < 4; k++) send(8'(8'h50 + k));
    out1_ready = 1'b0;
    send(8'h60);
    send(8'h61);
    out2_ready = 1'b0;
    chk("c_col2", col, 2);
    chk("c_l1_busy", out1_valid, 1);
    chk("c_l2_busy", out2_valid, 1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    chk("c_in_ready", in_ready, 1);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("c_out1_valid", out1_valid, 0);
    chk("c_out2_valid", out2_valid, 0);
    chk("c_sel", line_sel, 0);
    chk("c_col", col, 0);
    out1_ready = 1'b1; out2_ready = 1'b1;
    tick();
    tick();
    chk("c_no_ee1", out1_valid, 0);
    chk("c_no_ee2", out2_valid, 0);

    // Asynchronous reset mid-line
    out1_ready = 1'b0;
    send(8'h70);
    send(8'h71);
    chk("a_pre_valid", out1_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_out1_valid", out1_valid, 0);
    chk("a_out1_data", out1_data, 0);
    chk("a_in_ready", in_ready, 1);
    chk("a_col", col, 0);
    rst_n = 1'b1;
    #1;
    send(8'hAA);
    chk("a_aa_valid", out1_valid, 1);
    chk("a_aa_data", out1_data, 8'hAA);
    chk("a_aa_col", col, 1);
    chk("a_aa_sel", line_sel, 0);

    // Randomised valid/ready over 100 lines
    do_clear();
    begin
      int sent = 0;
      int exp_sel = 0;
      int exp_col = 0;
      for (int cyc = 0; cyc < 5000 && (sent < 400 || q1.size() + q2.size() > 0); cyc++) begin
        in_valid   = (sent < 400) && ($urandom_range(0, 3) != 0);
        in_data    = sent[7:0];
        out1_ready = ($urandom_range(0, 2) != 0);
        out2_ready = ($urandom_range(0, 2) != 0);
        if (out1_ready) begin
          chk("r_l1_valid", out1_valid, (q1.size() != 0));
          if (out1_valid && q1.size() != 0) chk("r_l1_data", out1_data, q1.pop_front());
        end
        if (out2_ready) begin
          chk("r_l2_valid", out2_valid, (q2.size() != 0));
          if (out2_valid && q2.size() != 0) chk("r_l2_data", out2_data, q2.pop_front());
        end
        if (in_valid && in_ready) begin
          chk("r_sel", line_sel, exp_sel);
          if (exp_sel == 0) q1.push_back(in_data);
          else              q2.push_back(in_data);
          sent++;
          if (exp_col == 3) begin
            exp_col = 0;
            exp_sel = exp_sel ^ 1;
          end else begin
            exp_col++;
          end
        end
        tick();
      end
      in_valid = 1'b0;
      chk("r_all_sent", sent, 400);
      chk("r_q1_drained", q1.size(), 0);
      chk("r_q2_drained", q2.size(), 0);
      chk("r_out1_idle", out1_valid, 0);
      chk("r_out2_idle", out2_valid, 0);
      chk("r_final_col", col, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
